arc_control_sequencer: RTL and testbench

- Sequences the ARC datapath through fetch, decode and execute.
- Holds a one-hot state register that resets to IF.
- Decodes the instruction fields from the IR and drives PC, IR, register-file, ALU and memory strobes.
- Supervises the memory ready handshake with a wait-state timeout that traps the machine on a stalled bus.

---
 rtl/arc_control_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_arc_control_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/arc_control_sequencer.sv
// ARC control sequencer: one-hot fetch/decode/execute FSM with a memory
// wait-state timeout that traps the machine when the bus stalls.
module arc_control_sequencer #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [1:0]  ir_op,
  input  logic [2:0]  ir_op2,
  input  logic [5:0]  ir_op3,
  input  logic        cond_true,
  input  logic        mem_ready,
  output logic [10:0] state,
  output logic        ir_load,
  output logic        pc_load,
  output logic [1:0]  pc_sel,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        rf_we,
  output logic [1:0]  rf_dsel,
  output logic        alu_en,
  output logic        psr_we,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  typedef enum logic [10:0] {
    S_IF    = 11'h001,
    S_ID    = 11'h002,
    S_ALU   = 11'h004,
    S_SETHI = 11'h008,
    S_BR    = 11'h010,
    S_CALL  = 11'h020,
    S_JMPL  = 11'h040,
    S_LD    = 11'h080,
    S_ST    = 11'h100,
    S_TRAP  = 11'h200,
    S_HALT  = 11'h400
  } state_e;

  localparam bit          TO_EN     = (TIMEOUT != 0);
  localparam int unsigned TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CNT_W-1:0] TO_LAST = TO_LAST_I[CNT_W-1:0];

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [1:0]         trap_cause_q, trap_cause_d;
  logic               timeout_hit;
  logic               mem_state;

  // Next-state, sticky trap cause and saturating wait counter
  always_comb begin
    state_d      = state_q;
    trap_cause_d = trap_cause_q;
    timeout_hit  = TO_EN && !mem_ready && (wait_cnt_q == TO_LAST);
    mem_state    = (state_q == S_IF) || (state_q == S_LD) || (state_q == S_ST);

    case (state_q)
      S_IF: begin
        if (!run) begin
          state_d = S_HALT;
        end else if (mem_ready) begin
          state_d = S_ID;
        end else if (timeout_hit) begin
          state_d      = S_TRAP;
          trap_cause_d = 2'b10;
        end
      end
      S_HALT: if (run) state_d = S_IF;
      S_ID: begin
        state_d      = S_TRAP;
        trap_cause_d = 2'b01;
        case (ir_op)
          2'b10: begin
            if (ir_op3 inside {6'b010000, 6'b010001, 6'b010010, 6'b010110, 6'b100110}) begin
              state_d      = S_ALU;
              trap_cause_d = trap_cause_q;
            end else if (ir_op3 == 6'b111000) begin
              state_d      = S_JMPL;
              trap_cause_d = trap_cause_q;
            end
          end
          2'b00: begin
            if (ir_op2 == 3'b100) begin
              state_d      = S_SETHI;
              trap_cause_d = trap_cause_q;
            end else if (ir_op2 == 3'b010) begin
              state_d      = S_BR;
              trap_cause_d = trap_cause_q;
            end
          end
          2'b01: begin
            state_d      = S_CALL;
            trap_cause_d = trap_cause_q;
          end
          default: begin
            if (ir_op3 == 6'b000000) begin
              state_d      = S_LD;
              trap_cause_d = trap_cause_q;
            end else if (ir_op3 == 6'b000100) begin
              state_d      = S_ST;
              trap_cause_d = trap_cause_q;
            end
          end
        endcase
      end
      S_ALU, S_SETHI, S_BR, S_CALL, S_JMPL: state_d = S_IF;
      S_LD, S_ST: begin
        if (mem_ready) begin
          state_d = S_IF;
        end else if (timeout_hit) begin
          state_d      = S_TRAP;
          trap_cause_d = 2'b10;
        end
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IF;
    endcase

    // Any state change clears the counter, so entry into IF/LD/ST starts at 0
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (mem_state && !mem_ready && (wait_cnt_q != '1)) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // State, counter and trap cause registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IF;
      wait_cnt_q   <= '0;
      trap_cause_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  // Strobe decode; IF strobes are gated by reset so they drop while it is held
  always_comb begin
    ir_load = 1'b0;
    pc_load = 1'b0;
    pc_sel  = 2'd0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    rf_we   = 1'b0;
    rf_dsel = 2'd0;
    alu_en  = 1'b0;
    psr_we  = 1'b0;
    trap    = 1'b0;
    case (state_q)
      S_IF: begin
        mem_rd  = run && !reset;
        ir_load = run && mem_ready && !reset;
      end
      S_ALU: begin
        alu_en  = 1'b1;
        rf_we   = 1'b1;
        psr_we  = ir_op3[4];
        pc_load = 1'b1;
      end
      S_SETHI: begin
        alu_en  = 1'b1;
        rf_we   = 1'b1;
        pc_load = 1'b1;
      end
      S_BR: begin
        pc_load = 1'b1;
        pc_sel  = cond_true ? 2'd1 : 2'd0;
      end
      S_CALL: begin
        rf_we   = 1'b1;
        rf_dsel = 2'd2;
        pc_load = 1'b1;
        pc_sel  = 2'd2;
      end
      S_JMPL: begin
        alu_en  = 1'b1;
        rf_we   = 1'b1;
        rf_dsel = 2'd2;
        pc_load = 1'b1;
        pc_sel  = 2'd3;
      end
      S_LD: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          rf_we   = 1'b1;
          rf_dsel = 2'd1;
          pc_load = 1'b1;
        end
      end
      S_ST: begin
        mem_wr = 1'b1;
        if (mem_ready) pc_load = 1'b1;
      end
      S_TRAP:  trap = 1'b1;
      default: ;
    endcase
  end

  assign state      = state_q;
  assign trap_cause = trap_cause_q;

endmodule

// File: tb/tb_arc_control_sequencer.sv
// Scoreboard bench for arc_control_sequencer: directed per-cycle vectors
// push hand-computed expected outputs; a negedge monitor pops and compares.
module tb_arc_control_sequencer;

  localparam int IF = 0, ID = 1, ALU = 2, SETHI = 3, BR = 4, CALL = 5,
                 JMPL = 6, LD = 7, ST = 8, TRAP = 9, HALT = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [1:0]  ir_op = 2'b00;
  logic [2:0]  ir_op2 = 3'b000;
  logic [5:0]  ir_op3 = 6'b000000;
  logic        cond_true = 1'b0;
  logic        mem_ready = 1'b0;
  logic [10:0] state;
  logic        ir_load, pc_load, mem_rd, mem_wr, rf_we, alu_en, psr_we, trap;
  logic [1:0]  pc_sel, rf_dsel, trap_cause;

  int checks = 0;
  int errors = 0;

  string       nm_q[$];
  logic [24:0] exp_q[$];

  arc_control_sequencer #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .run(run), .ir_op(ir_op), .ir_op2(ir_op2),
    .ir_op3(ir_op3), .cond_true(cond_true), .mem_ready(mem_ready),
    .state(state), .ir_load(ir_load), .pc_load(pc_load), .pc_sel(pc_sel),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .rf_we(rf_we), .rf_dsel(rf_dsel),
    .alu_en(alu_en), .psr_we(psr_we), .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  // Expected vector: {state, ir_load, pc_load, pc_sel, mem_rd, mem_wr, rf_we, rf_dsel, alu_en, psr_we, trap, trap_cause}
  function automatic logic [24:0] mk(input int st, input logic il, input logic pl,
                                     input logic [1:0] ps, input logic rd, input logic wr,
                                     input logic we, input logic [1:0] ds, input logic al,
                                     input logic pw, input logic tr, input logic [1:0] tc);
    logic [10:0] s;
    s = 11'd1 << st;
    return {s, il, pl, ps, rd, wr, we, ds, al, pw, tr, tc};
  endfunction

  task automatic drv(input logic rst_i, input logic run_i, input logic [1:0] op,
                     input logic [5:0] op3, input logic ct, input logic rdy,
                     input string nm, input logic [24:0] e);
    @(posedge clk);
    #1;
    reset     = rst_i;
    run       = run_i;
    ir_op     = op;
    ir_op3    = op3;
    ir_op2    = op3[5:3];
    cond_true = ct;
    mem_ready = rdy;
    nm_q.push_back(nm);
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are settled mid-cycle, compare against the oldest expectation
  always @(negedge clk) begin
    logic [24:0] act;
    logic [24:0] e;
    string       n;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      n   = nm_q.pop_front();
      act = {state, ir_load, pc_load, pc_sel, mem_rd, mem_wr, rf_we, rf_dsel,
             alu_en, psr_we, trap, trap_cause};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s got state=%h strobes=%b cause=%b expected state=%h strobes=%b cause=%b",
                 n, act[24:14], act[13:2], act[1:0], e[24:14], e[13:2], e[1:0]);
      end
    end
  end

  initial begin
    logic [24:0] z_if;
    logic [24:0] f_if;
    z_if = mk(IF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    f_if = mk(IF, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    drv(1, 0, 2'b00, 6'h00, 0, 0, "reset", z_if);

    // addcc
    drv(0, 1, 2'b10, 6'b010000, 0, 1, "addcc_if", f_if);
    drv(0, 1, 2'b10, 6'b010000, 0, 1, "addcc_id", mk(ID, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drv(0, 1, 2'b10, 6'b010000, 0, 1, "addcc_alu", mk(ALU, 0, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0));
    // srl: no flag write
    drv(0, 1, 2'b10, 6'b100110, 0, 1, "srl_if", f_if);
    drv(0, 1, 2'b10, 6'b100110, 0, 1, "srl_id", mk(ID, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drv(0, 1, 2'b10, 6'b100110, 0, 1, "srl_alu", mk(ALU, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    // ld with two wait states
    drv(0, 1, 2'b11, 6'b000000, 0, 1, "ld_if", f_if);
    drv(0, 1, 2'b11, 6'b000000, 0, 1, "ld_id", mk(ID, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drv(0, 1, 2'b11, 6'b000000, 0, 0, "ld_wait1", mk(LD, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    drv(0, 1, 2'b11, 6'b000000, 0, 0, "ld_wait2", mk(LD, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    drv(0, 1, 2'b11, 6'b000000, 0, 1, "ld_done", mk(LD, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0));
    // branch taken / not taken
    drv(0, 1, 2'b00, 6'b010000, 1, 1, "bt_if", f_if);
    drv(0, 1, 2'b00, 6'b010000, 1, 1, "bt_id", mk(ID, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drv(0, 1, 2'b00, 6'b010000, 1, 1, "br_taken", mk(BR, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    drv(0, 1, 2'b00, 6'b010000, 0, 1, "bn_if", f_if);
    drv(0, 1, 2'b00, 6'b010000, 0, 1, "bn_id", mk(ID, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drv(0, 1, 2'b00, 6'b010000, 0, 1, "br_not_taken", mk(BR, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // call, jmpl, sethi
    drv(0, 1, 2'b01, 6'b000000, 0, 1, "call_if", f_if);
    drv(0, 1, 2'b01, 6'b000000, 0, 1, "call_id", mk(ID, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drv(0, 1, 2'b01, 6'b000000, 0, 1, "call_ex", mk(CALL, 0, 1, 2, 0, 0, 1, 2, 0, 0, 0, 0));
    drv(0, 1, 2'b10, 6'b111000, 0, 1, "jmpl_if", f_if);
    drv(0, 1, 2'b10, 6'b111000, 0, 1, "jmpl_id", mk(ID, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drv(0, 1, 2'b10, 6'b111000, 0, 1, "jmpl_ex", mk(JMPL, 0, 1, 3, 0, 0, 1, 2, 1, 0, 0, 0));
    drv(0, 1, 2'b00, 6'b100000, 0, 1, "sethi_if", f_if);
    drv(0, 1, 2'b00, 6'b100000, 0, 1, "sethi_id", mk(ID, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drv(0, 1, 2'b00, 6'b100000, 0, 1, "sethi_ex", mk(SETHI, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    // st: ready arrives on the last allowed wait cycle and wins
    drv(0, 1, 2'b11, 6'b000100, 0, 1, "stl_if", f_if);
    drv(0, 1, 2'b11, 6'b000100, 0, 1, "stl_id", mk(ID, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      drv(0, 1, 2'b11, 6'b000100, 0, 0, "stl_wait", mk(ST, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    drv(0, 1, 2'b11, 6'b000100, 0, 1, "stl_ready_last", mk(ST, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    // fetch stall, then halt and resume
    drv(0, 1, 2'b11, 6'b000000, 0, 0, "if_stall", mk(IF, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    drv(0, 0, 2'b11, 6'b000000, 0, 1, "if_run_off", z_if);
    drv(0, 0, 2'b11, 6'b000000, 0, 1, "halt_idle", mk(HALT, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drv(0, 1, 2'b11, 6'b000000, 0, 1, "halt_resume", mk(HALT, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // ld interrupted by reset during a wait state
    drv(0, 1, 2'b11, 6'b000000, 0, 1, "ldr_if", f_if);
    drv(0, 1, 2'b11, 6'b000000, 0, 1, "ldr_id", mk(ID, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drv(0, 1, 2'b11, 6'b000000, 0, 0, "ldr_wait", mk(LD, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    drv(1, 1, 2'b11, 6'b000000, 0, 1, "reset_mid_ld", z_if);
    // first cycle after reset release, then st timeout
    drv(0, 1, 2'b11, 6'b000100, 0, 1, "post_reset_if", f_if);
    drv(0, 1, 2'b11, 6'b000100, 0, 1, "sto_id", mk(ID, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      drv(0, 1, 2'b11, 6'b000100, 0, 0, "sto_wait", mk(ST, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    drv(0, 1, 2'b11, 6'b000100, 0, 1, "sto_trap", mk(TRAP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10));
    drv(0, 0, 2'b11, 6'b000100, 0, 0, "sto_trap_hold", mk(TRAP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10));
    drv(1, 1, 2'b00, 6'b111000, 0, 1, "reset_from_trap", z_if);
    // illegal opcode: op=00 op2=111
    drv(0, 1, 2'b00, 6'b111000, 0, 1, "ill_if", f_if);
    drv(0, 1, 2'b00, 6'b111000, 0, 1, "ill_id", mk(ID, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 20; i++)
      drv(0, i[0], 2'b00, 6'b111000, i[2], i[1], "ill_trap",
          mk(TRAP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01));

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0 pending", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
